// File: rtl/hms_timer.sv
// rtl/hms_timer.sv - HH:MM:SS up/down timer with preset load and seven-segment outputs
module seg7dec (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    // Active-low segments ordered {g,f,e,d,c,b,a}
    always_comb begin
        case (bcd)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'ha: seg = 7'b0001000;
            4'hb: seg = 7'b0000011;
            4'hc: seg = 7'b1000110;
            4'hd: seg = 7'b0100001;
            4'he: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end
endmodule

module hms_timer #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int HOUR_MOD = 24
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        CLEAR,
    input  logic        DOWN,
    input  logic        LOAD,
    input  logic [7:0]  LD_HOUR,
    input  logic [7:0]  LD_MIN,
    input  logic [7:0]  LD_SEC,
    output logic [23:0] TIME_BCD,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        RUNNING,
    output logic        DONE,
    output logic        LOAD_ERR
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [3:0] HM1_T = 4'((HOUR_MOD - 1) / 10);
    localparam logic [3:0] HM1_U = 4'((HOUR_MOD - 1) % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t        state, state_n;
    logic [23:0]   time_q, time_n, time_step;
    logic [CW-1:0] cnt, cnt_n;
    logic          running_q, done_q, done_n, lerr_q, lerr_n;
    logic          tick, ld_valid;
    logic [7:0]    ld_hours;

    logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
    logic [3:0] n_hr_t, n_hr_u, n_min_t, n_min_u, n_sec_t, n_sec_u;

    assign {hr_t, hr_u, min_t, min_u, sec_t, sec_u} = time_q;
    assign tick = (state == RUN) && (cnt == CNT_MAX);

    // One-second step of the digit chain in the direction DOWN selects
    always_comb begin
        {n_hr_t, n_hr_u, n_min_t, n_min_u, n_sec_t, n_sec_u} = time_q;
        if (!DOWN) begin
            if (sec_u != 4'd9) n_sec_u = sec_u + 4'd1;
            else begin
                n_sec_u = 4'd0;
                if (sec_t != 4'd5) n_sec_t = sec_t + 4'd1;
                else begin
                    n_sec_t = 4'd0;
                    if (min_u != 4'd9) n_min_u = min_u + 4'd1;
                    else begin
                        n_min_u = 4'd0;
                        if (min_t != 4'd5) n_min_t = min_t + 4'd1;
                        else begin
                            n_min_t = 4'd0;
                            if (hr_t == HM1_T && hr_u == HM1_U) begin
                                n_hr_t = 4'd0;
                                n_hr_u = 4'd0;
                            end else if (hr_u == 4'd9) begin
                                n_hr_t = hr_t + 4'd1;
                                n_hr_u = 4'd0;
                            end else n_hr_u = hr_u + 4'd1;
                        end
                    end
                end
            end
        end else begin
            if (sec_u != 4'd0) n_sec_u = sec_u - 4'd1;
            else begin
                n_sec_u = 4'd9;
                if (sec_t != 4'd0) n_sec_t = sec_t - 4'd1;
                else begin
                    n_sec_t = 4'd5;
                    if (min_u != 4'd0) n_min_u = min_u - 4'd1;
                    else begin
                        n_min_u = 4'd9;
                        if (min_t != 4'd0) n_min_t = min_t - 4'd1;
                        else begin
                            n_min_t = 4'd5;
                            if (hr_t == 4'd0 && hr_u == 4'd0) begin
                                n_hr_t = HM1_T;
                                n_hr_u = HM1_U;
                            end else if (hr_u == 4'd0) begin
                                n_hr_t = hr_t - 4'd1;
                                n_hr_u = 4'd9;
                            end else n_hr_u = hr_u - 4'd1;
                        end
                    end
                end
            end
        end
        time_step = {n_hr_t, n_hr_u, n_min_t, n_min_u, n_sec_t, n_sec_u};
    end

    assign ld_hours = {4'd0, LD_HOUR[7:4]} * 8'd10 + {4'd0, LD_HOUR[3:0]};
    assign ld_valid = (LD_SEC[3:0] <= 4'd9) && (LD_SEC[7:4] <= 4'd5) &&
                      (LD_MIN[3:0] <= 4'd9) && (LD_MIN[7:4] <= 4'd5) &&
                      (LD_HOUR[3:0] <= 4'd9) && (LD_HOUR[7:4] <= 4'd9) &&
                      (ld_hours < 8'(HOUR_MOD));

    always_comb begin
        state_n = state;
        time_n  = time_q;
        cnt_n   = cnt;
        done_n  = 1'b0;
        lerr_n  = 1'b0;
        if (CLEAR) begin
            state_n = IDLE;
            time_n  = 24'h000000;
            cnt_n   = '0;
        end else begin
            if (state == RUN) cnt_n = tick ? '0 : cnt + 1'b1;
            if (tick) begin
                time_n = time_step;
                if (DOWN && time_step == 24'h000000) begin
                    state_n = EXPIRED;
                    done_n  = 1'b1;
                end
            end
            // LOAD outranks START even when the LOAD itself is ignored
            if (LOAD) begin
                if (state == IDLE || state == PAUSE) begin
                    if (ld_valid) begin
                        time_n = {LD_HOUR, LD_MIN, LD_SEC};
                        cnt_n  = '0;
                    end else lerr_n = 1'b1;
                end
            end else if (START) begin
                case (state)
                    IDLE, PAUSE: if (!(DOWN && time_q == 24'h000000)) state_n = RUN;
                    RUN:         if (state_n == RUN) state_n = PAUSE;
                    default:     ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            time_q    <= 24'h000000;
            cnt       <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            time_q    <= time_n;
            cnt       <= cnt_n;
            running_q <= (state_n == RUN);
            done_q    <= done_n;
            lerr_q    <= lerr_n;
        end
    end

    assign TIME_BCD = time_q;
    assign RUNNING  = running_q;
    assign DONE     = done_q;
    assign LOAD_ERR = lerr_q;

    seg7dec u_hex0 (.bcd(sec_u), .seg(HEX0));
    seg7dec u_hex1 (.bcd(sec_t), .seg(HEX1));
    seg7dec u_hex2 (.bcd(min_u), .seg(HEX2));
    seg7dec u_hex3 (.bcd(min_t), .seg(HEX3));
    seg7dec u_hex4 (.bcd(hr_u),  .seg(HEX4));
    seg7dec u_hex5 (.bcd(hr_t),  .seg(HEX5));
endmodule

// File: tb/tb_hms_timer.sv
// tb/tb_hms_timer.sv - bench for hms_timer at HOUR_MOD 24 and 12 against a seconds-count model
module tb_hms_timer;
    logic CLK = 1'b0;
    logic RST, START, CLEAR, DOWN, LOAD;
    logic [7:0] LD_HOUR, LD_MIN, LD_SEC;
    logic [23:0] time_a, time_b;
    logic [6:0] hx_a [0:5];
    logic [6:0] hx_b [0:5];
    logic run_a, run_b, done_a, done_b, lerr_a, lerr_b;

    int vectors = 0;
    int miscompares = 0;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
    int mods [2] = '{24, 12};
    int m_st [2], m_t [2], m_cnt [2];
    bit m_done [2], m_lerr [2];
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    always #5 CLK = ~CLK;

    hms_timer #(.CLK_HZ(10), .TICK_HZ(1), .HOUR_MOD(24)) u_dut_a (
        .CLK(CLK), .RST(RST), .START(START), .CLEAR(CLEAR), .DOWN(DOWN), .LOAD(LOAD),
        .LD_HOUR(LD_HOUR), .LD_MIN(LD_MIN), .LD_SEC(LD_SEC), .TIME_BCD(time_a),
        .HEX0(hx_a[0]), .HEX1(hx_a[1]), .HEX2(hx_a[2]), .HEX3(hx_a[3]), .HEX4(hx_a[4]), .HEX5(hx_a[5]),
        .RUNNING(run_a), .DONE(done_a), .LOAD_ERR(lerr_a));

    hms_timer #(.CLK_HZ(10), .TICK_HZ(1), .HOUR_MOD(12)) u_dut_b (
        .CLK(CLK), .RST(RST), .START(START), .CLEAR(CLEAR), .DOWN(DOWN), .LOAD(LOAD),
        .LD_HOUR(LD_HOUR), .LD_MIN(LD_MIN), .LD_SEC(LD_SEC), .TIME_BCD(time_b),
        .HEX0(hx_b[0]), .HEX1(hx_b[1]), .HEX2(hx_b[2]), .HEX3(hx_b[3]), .HEX4(hx_b[4]), .HEX5(hx_b[5]),
        .RUNNING(run_b), .DONE(done_b), .LOAD_ERR(lerr_b));

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(int t);
        int h = t / 3600;
        int mi = (t / 60) % 60;
        int s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit ld_ok(int hmod);
        int ht = int'(LD_HOUR[7:4]), hu = int'(LD_HOUR[3:0]);
        int mt = int'(LD_MIN[7:4]),  mu = int'(LD_MIN[3:0]);
        int st = int'(LD_SEC[7:4]),  su = int'(LD_SEC[3:0]);
        return su <= 9 && mu <= 9 && hu <= 9 && st <= 5 && mt <= 5 && ht <= 9 && (ht * 10 + hu) < hmod;
    endfunction

    // Time is kept as total seconds; the display is derived from it
    task automatic model_step(int m);
        int period = mods[m] * 3600;
        int pre = m_st[m];
        bit tk;
        m_done[m] = 1'b0;
        m_lerr[m] = 1'b0;
        if (RST) begin
            m_st[m] = S_IDLE; m_t[m] = 0; m_cnt[m] = 0;
        end else if (CLEAR) begin
            m_st[m] = S_IDLE; m_t[m] = 0; m_cnt[m] = 0;
        end else begin
            tk = (pre == S_RUN) && (m_cnt[m] == 9);
            if (pre == S_RUN) m_cnt[m] = tk ? 0 : m_cnt[m] + 1;
            if (tk) begin
                m_t[m] = DOWN ? (m_t[m] + period - 1) % period : (m_t[m] + 1) % period;
                if (DOWN && m_t[m] == 0) begin
                    m_st[m] = S_EXP;
                    m_done[m] = 1'b1;
                end
            end
            if (LOAD) begin
                if (pre == S_IDLE || pre == S_PAUSE) begin
                    if (ld_ok(mods[m])) begin
                        m_t[m] = int'(LD_HOUR[7:4]) * 36000 + int'(LD_HOUR[3:0]) * 3600 +
                                 int'(LD_MIN[7:4]) * 600 + int'(LD_MIN[3:0]) * 60 +
                                 int'(LD_SEC[7:4]) * 10 + int'(LD_SEC[3:0]);
                        m_cnt[m] = 0;
                    end else m_lerr[m] = 1'b1;
                end
            end else if (START) begin
                if ((pre == S_IDLE || pre == S_PAUSE) && !(DOWN && m_t[m] == 0)) m_st[m] = S_RUN;
                else if (pre == S_RUN && m_st[m] == S_RUN) m_st[m] = S_PAUSE;
            end
        end
    endtask

    task automatic compare_all();
        logic [23:0] ea, eb;
        ea = to_bcd(m_t[0]);
        eb = to_bcd(m_t[1]);
        check("time_24", time_a, ea);
        check("time_12", time_b, eb);
        check("running_24", run_a, m_st[0] == S_RUN);
        check("running_12", run_b, m_st[1] == S_RUN);
        check("done_24", done_a, m_done[0]);
        check("done_12", done_b, m_done[1]);
        check("lerr_24", lerr_a, m_lerr[0]);
        check("lerr_12", lerr_b, m_lerr[1]);
        check("hex0_24", hx_a[0], seg_tab[ea[3:0]]);
        check("hex5_24", hx_a[5], seg_tab[ea[23:20]]);
        check("hex4_12", hx_b[4], seg_tab[eb[19:16]]);
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge CLK);
        #1;
        compare_all();
        RST = 1'b0; START = 1'b0; CLEAR = 1'b0; LOAD = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(logic [7:0] h, logic [7:0] mi, logic [7:0] s);
        LD_HOUR = h; LD_MIN = mi; LD_SEC = s; LOAD = 1'b1;
        cycle();
    endtask

    task automatic do_start();
        START = 1'b1;
        cycle();
    endtask

    task automatic do_clear();
        CLEAR = 1'b1;
        cycle();
    endtask

    initial begin
        int dcount;
        RST = 1'b1; START = 1'b0; CLEAR = 1'b0; DOWN = 1'b0; LOAD = 1'b0;
        LD_HOUR = 8'h00; LD_MIN = 8'h00; LD_SEC = 8'h00;
        for (int i = 0; i < 8; i++) m_st[i % 2] = S_IDLE;
        m_t = '{0, 0}; m_cnt = '{0, 0};
        cycle();
        check("reset_time", time_a, 24'h000000);
        check("reset_hex", hx_a[3], 7'h40);

        // Up count for one hour
        do_start();
        run(36000);
        check("hour_up", time_a, 24'h010000);
        check("hour_running", run_a, 1'b1);

        // Wrap at the hour modulus
        do_clear();
        do_load(8'h23, 8'h59, 8'h58);
        do_start();
        run(20);
        check("wrap24", time_a, 24'h000000);
        do_clear();
        do_load(8'h11, 8'h59, 8'h59);
        do_start();
        run(10);
        check("wrap12", time_b, 24'h000000);
        check("wrap12_other", time_a, 24'h120000);

        // Countdown to expiry
        do_clear();
        DOWN = 1'b1;
        do_load(8'h00, 8'h01, 8'h00);
        do_start();
        run(10);
        check("down_first", time_a, 24'h000059);
        dcount = 0;
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (done_a) dcount++;
        end
        check("done_count", dcount, 1);
        check("expired_running", run_a, 1'b0);
        DOWN = 1'b0;
        do_start();
        check("expired_start", run_a, 1'b0);
        do_clear();
        do_start();
        check("clear_then_run", run_a, 1'b1);

        // Rejected and ignored loads
        do_clear();
        do_load(8'h01, 8'h02, 8'h03);
        do_load(8'h00, 8'h60, 8'h00);
        check("bad_min_err", lerr_a, 1'b1);
        do_load(8'h24, 8'h00, 8'h00);
        check("bad_hour_err", lerr_a, 1'b1);
        do_load(8'h00, 8'h00, 8'h0a);
        check("bad_sec_err", lerr_a, 1'b1);
        check("bad_keep", time_a, 24'h010203);
        do_start();
        do_load(8'h05, 8'h05, 8'h05);
        check("run_load_err", lerr_a, 1'b0);
        check("run_load_keep", time_a, 24'h010203);

        // Pause keeps the sub-second phase
        do_clear();
        do_start();
        run(5);
        do_start();
        run(50);
        do_start();
        run(3);
        check("resume_early", time_a, 24'h000000);
        cycle();
        check("resume_tick", time_a, 24'h000001);
        run(2);
        do_start();
        LD_HOUR = 8'h07; LD_MIN = 8'h08; LD_SEC = 8'h09; LOAD = 1'b1; START = 1'b1;
        cycle();
        check("pause_load", time_a, 24'h070809);
        check("pause_stays", run_a, 1'b0);

        // Reset mid-run, and zero-time countdown start
        do_clear();
        do_load(8'h12, 8'h34, 8'h56);
        do_start();
        run(25);
        check("pre_reset", time_a, 24'h123458);
        RST = 1'b1;
        cycle();
        check("reset_mid", time_a, 24'h000000);
        check("reset_run", run_a, 1'b0);
        DOWN = 1'b1;
        do_start();
        check("zero_down_start", run_a, 1'b0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            RST   = ($urandom_range(599) == 0);
            CLEAR = ($urandom_range(79) == 0);
            LOAD  = ($urandom_range(29) == 0);
            START = ($urandom_range(9) == 0);
            if ($urandom_range(99) == 0) DOWN = ~DOWN;
            LD_HOUR = {4'($urandom_range(2)), 4'($urandom_range(10))};
            LD_MIN  = {4'($urandom_range(6)), 4'($urandom_range(10))};
            LD_SEC  = {4'($urandom_range(6)), 4'($urandom_range(10))};
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
